mc_main_fsm: RTL and testbench
==============================

Name: mc_main_fsm

Overview:
Multicycle control FSM that sits directly upstream of the ALU decoder. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives ALUOp[1:0] into the ALU decoder. It also drives every datapath mux select and write enable for the shared-memory multicycle core. Supported instructions: lw, sw, R-type, I-type ALU, jal and beq. Any other opcode traps.

Parameters:
- RESET_STATE, S_FETCH, state the FSM enters on reset (fixed; not for override; documentation only).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- op  input  7  opcode field from the instruction register; stable from DECODE onward.
- zero  input  1  ALU zero flag, used only in S_BEQ.
- pc_write  output  1  PC register enable.
- adr_src  output  1  memory address select: 0 = PC, 1 = Result.
- mem_write  output  1  data memory write enable.
- ir_write  output  1  instruction register (and OldPC) enable.
- reg_write  output  1  register file write enable.
- result_src  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  output  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = rd1.
- alu_src_b  output  2  ALU operand B select: 00 = rd2, 01 = ImmExt, 10 = constant 4.
- alu_op  output  2  to the ALU decoder: 00 = add, 01 = sub, 10 = decode funct fields.
- imm_src  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- instr_done  output  1  one-cycle pulse in the final state of each instruction.
- illegal_op  output  1  high while the FSM sits in S_TRAP.

Behaviour:
- Single always_ff holds the state register; asynchronous reset forces S_FETCH.
- All outputs are Moore decodes of the state, with two exceptions:
  - pc_write = pc_update | (branch & zero), where pc_update and branch are internal Moore signals.
  - imm_src is a pure decode of op.
- Output reset values (state = S_FETCH): ir_write = 1, pc_write = 1, alu_src_b = 10, result_src = 10. All other outputs are 0.
- Default for every output in every state is 0 unless listed below.
- States, their outputs, and next state:
  - S_FETCH: adr_src = 0, ir_write = 1, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_src = 10, pc_update = 1. Next: S_DECODE.
  - S_DECODE: alu_src_a = 01, alu_src_b = 01, alu_op = 00 (branch/jump target into ALUOut). Next state by op:
    - 0000011 or 0100011 -> S_MEMADR
    - 0110011 -> S_EXECR
    - 0010011 -> S_EXECI
    - 1101111 -> S_JAL
    - 1100011 -> S_BEQ
    - any other value -> S_TRAP
  - S_MEMADR: alu_src_a = 10, alu_src_b = 01, alu_op = 00. Next: op = 0000011 -> S_MEMREAD, otherwise -> S_MEMWRITE.
  - S_MEMREAD: result_src = 00, adr_src = 1. Next: S_MEMWB.
  - S_MEMWB: result_src = 01, reg_write = 1, instr_done = 1. Next: S_FETCH.
  - S_MEMWRITE: result_src = 00, adr_src = 1, mem_write = 1, instr_done = 1. Next: S_FETCH.
  - S_EXECR: alu_src_a = 10, alu_src_b = 00, alu_op = 10. Next: S_ALUWB.
  - S_EXECI: alu_src_a = 10, alu_src_b = 01, alu_op = 10. Next: S_ALUWB.
  - S_JAL: alu_src_a = 01, alu_src_b = 10, alu_op = 00, result_src = 00, pc_update = 1. Next: S_ALUWB.
  - S_ALUWB: result_src = 00, reg_write = 1, instr_done = 1. Next: S_FETCH.
  - S_BEQ: alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00, branch = 1, instr_done = 1. Next: S_FETCH.
  - S_TRAP: illegal_op = 1; all enables are 0. Stays in S_TRAP until reset.
- Latency in cycles, counted from entering S_FETCH to re-entering it: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.
- The FSM never asserts mem_write and reg_write in the same cycle.
- zero is ignored outside S_BEQ: pc_write must not glitch high in any other state.
- Reset asserted mid-instruction: the state goes to S_FETCH asynchronously, with no completion of the current instruction and no instr_done pulse.
- Unused state encodings decode to S_FETCH.

Decomposition:
- Shared package mc_pkg holds:
  - the state enum (4-bit),
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ,
  - the alu_op, result_src, alu_src_a, alu_src_b and imm_src encodings, also used by datapath and ALU decoder.
- One sub-module: mc_imm_dec, a combinational op -> imm_src decode (00 for unknown op).

Test Plan:
1. Reset while in S_MEMREAD -> state = S_FETCH immediately; ir_write = 1, pc_write = 1, alu_src_b = 10, mem_write = 0, reg_write = 0.
2. op = 0000011 (lw) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write = 1 and result_src = 01 only in cycle 5; instr_done pulses once.
3. op = 0100011 (sw) -> mem_write = 1 with adr_src = 1 in cycle 4 only; imm_src = 01; back in S_FETCH at cycle 5.
4. op = 1100011 (beq) with zero = 1 in S_BEQ -> pc_write = 1, alu_op = 01. With zero = 0 -> pc_write = 0. Hold zero = 1 during S_DECODE -> pc_write stays 0.
5. op = 0110011, then 0010011, then 1101111 back-to-back -> alu_op = 10, 10, 00 in execute; each instruction reaches S_ALUWB on cycle 4; jal asserts pc_write in S_JAL.
6. op = 0000000 -> S_TRAP after decode; illegal_op = 1 and all enables 0 for 20+ cycles; reset returns to S_FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control path: FSM states, opcodes and
// the mux/ALU select codes also used by the datapath and ALU decoder.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  // Fixed reset target; not intended as an override point.
  localparam state_t RESET_STATE = S_FETCH;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_imm_dec.sv
// Combinational opcode -> immediate-format decode; unknown opcodes give I-format.
module mc_imm_dec
  import mc_pkg::*;
(
  input  logic [6:0] op_i,
  output logic [1:0] imm_src_o
);

  always_comb begin
    imm_src_o = IMM_I;
    case (op_i)
      OP_SW:   imm_src_o = IMM_S;
      OP_BEQ:  imm_src_o = IMM_B;
      OP_JAL:  imm_src_o = IMM_J;
      default: imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/mc_main_fsm.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select, write enable and ALUOp for the ALU decoder.
module mc_main_fsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t state_q, state_d;
  state_t st_eff;
  logic   pc_update;
  logic   branch;

  // Encodings past S_TRAP are unreachable; treat them as fetch.
  always_comb begin
    st_eff = state_q;
    if (state_q > S_TRAP) st_eff = S_FETCH;
  end

  always_comb begin
    state_d = S_FETCH;
    case (st_eff)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (st_eff)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
      end
      // Precompute branch/jump target into ALUOut while the opcode resolves.
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_TRAP: illegal_op = 1'b1;
      default: ;
    endcase
  end

  // branch is only set in S_BEQ, so zero cannot reach pc_write elsewhere.
  assign pc_write = pc_update | (branch & zero);

  mc_imm_dec u_imm_dec (
    .op_i      (op),
    .imm_src_o (imm_src)
  );

endmodule

// File: tb/tb_mc_main_fsm.sv
// Directed bench for mc_main_fsm: expected per-cycle output vectors are queued
// from a reference table of the control states and compared as the FSM runs.
module tb_mc_main_fsm;

  localparam int T_F = 0, T_D = 1, T_MA = 2, T_MR = 3, T_MWB = 4, T_MW = 5;
  localparam int T_XR = 6, T_XI = 7, T_J = 8, T_AWB = 9, T_BEQ = 10, T_TRAP = 11;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JAL = 7'b1101111, BEQ = 7'b1100011;

  logic       clk, reset, zero;
  logic [6:0] op;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;

  typedef struct {
    string       tag;
    logic [16:0] v;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  mc_main_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] obs_vec();
    return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
            alu_src_a, alu_src_b, alu_op, imm_src, instr_done, illegal_op};
  endfunction

  // Expected outputs for a control state, taken from the state/output table.
  function automatic logic [16:0] ref_out(input int st, input logic [6:0] opv, input logic z);
    logic pcu, br, adr, mw, irw, rw, done, ill;
    logic [1:0] rs, sa, sbs, ao, imm;
    pcu = 0; br = 0; adr = 0; mw = 0; irw = 0; rw = 0; done = 0; ill = 0;
    rs = 2'b00; sa = 2'b00; sbs = 2'b00; ao = 2'b00;
    case (opv)
      SW:      imm = 2'b01;
      BEQ:     imm = 2'b10;
      JAL:     imm = 2'b11;
      default: imm = 2'b00;
    endcase
    case (st)
      T_F:    begin irw = 1; sbs = 2'b10; rs = 2'b10; pcu = 1; end
      T_D:    begin sa = 2'b01; sbs = 2'b01; end
      T_MA:   begin sa = 2'b10; sbs = 2'b01; end
      T_MR:   begin adr = 1; end
      T_MWB:  begin rs = 2'b01; rw = 1; done = 1; end
      T_MW:   begin adr = 1; mw = 1; done = 1; end
      T_XR:   begin sa = 2'b10; ao = 2'b10; end
      T_XI:   begin sa = 2'b10; sbs = 2'b01; ao = 2'b10; end
      T_J:    begin sa = 2'b01; sbs = 2'b10; pcu = 1; end
      T_AWB:  begin rw = 1; done = 1; end
      T_BEQ:  begin sa = 2'b10; ao = 2'b01; br = 1; done = 1; end
      T_TRAP: begin ill = 1; end
      default: ;
    endcase
    return {pcu | (br & z), adr, mw, irw, rw, rs, sa, sbs, ao, imm, done, ill};
  endfunction

  task automatic compare_next();
    exp_t e;
    logic [16:0] o;
    e = sb.pop_front();
    o = obs_vec();
    checks++;
    assert (o === e.v) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", e.tag, o, e.v);
    end
  endtask

  // Entered at a negedge; drives one instruction and checks each cycle.
  task automatic run_path(input string name, input logic [6:0] opv, input logic z, input int path[$]);
    op   = opv;
    zero = z;
    foreach (path[i]) begin
      exp_t e;
      e.tag = $sformatf("%s[%0d]", name, i);
      e.v   = ref_out(path[i], opv, z);
      sb.push_back(e);
    end
    foreach (path[i]) begin
      #1;
      compare_next();
      @(negedge clk);
    end
  endtask

  task automatic check_state(input string name, input int st);
    exp_t e;
    e.tag = name;
    e.v   = ref_out(st, op, zero);
    sb.push_back(e);
    #1;
    compare_next();
  endtask

  initial begin
    int p[$];
    reset = 1'b1;
    op    = 7'b0;
    zero  = 1'b0;
    repeat (2) @(negedge clk);
    check_state("reset_vals", T_F);
    reset = 1'b0;

    // lw interrupted in MEMREAD by an asynchronous reset
    p = {T_F, T_D, T_MA};
    run_path("lw_part", LW, 1'b0, p);
    check_state("lw_in_memread", T_MR);
    #2 reset = 1'b1;
    check_state("async_reset", T_F);
    @(negedge clk);
    check_state("reset_held", T_F);
    reset = 1'b0;

    p = {T_F, T_D, T_MA, T_MR, T_MWB};
    run_path("lw", LW, 1'b1, p);
    p = {T_F, T_D, T_MA, T_MW};
    run_path("sw", SW, 1'b0, p);
    p = {T_F, T_D, T_BEQ};
    run_path("beq_z1", BEQ, 1'b1, p);
    run_path("beq_z0", BEQ, 1'b0, p);
    p = {T_F, T_D, T_XR, T_AWB};
    run_path("rtype", RT, 1'b1, p);
    p = {T_F, T_D, T_XI, T_AWB};
    run_path("itype", IT, 1'b0, p);
    p = {T_F, T_D, T_J, T_AWB};
    run_path("jal", JAL, 1'b1, p);

    p = {T_F, T_D};
    for (int i = 0; i < 22; i++) p.push_back(T_TRAP);
    run_path("trap_op0", 7'b0000000, 1'b1, p);
    reset = 1'b1;
    check_state("trap_reset", T_F);
    @(negedge clk);
    reset = 1'b0;

    p = {T_F, T_D, T_TRAP, T_TRAP};
    run_path("trap_lui", 7'b0110111, 1'b0, p);
    reset = 1'b1;
    check_state("trap_reset2", T_F);
    @(negedge clk);
    reset = 1'b0;

    p = {T_F, T_D, T_MA, T_MW};
    run_path("sw_after", SW, 1'b1, p);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
